// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer (master) and the PLL/system side (slave).
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_resetn;
  logic       locked;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  modport master (
    input  pll_lock,
    output pll_reset, sys_resetn, locked, relock_count, timeout_count
  );

  modport slave (
    output pll_lock,
    input  pll_reset, sys_resetn, locked, relock_count, timeout_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Board-clock PLL supervisor: pulses the PLL reset, qualifies lock, then releases
// the system reset; re-resets the system on lock loss and the PLL on lock timeout.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 64,
  parameter int CNT_W               = 20
) (
  input  logic                  clk,
  input  logic                  resetn,
  pll_reset_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_HOLD,
    S_RUN
  } state_e;

  state_e                 state_q;
  logic                   run_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       stab_q;
  logic                   pll_reset_q;
  logic                   sys_resetn_q;
  logic                   locked_q;
  logic [7:0]             relock_q;
  logic [7:0]             tmo_q;

  logic                   lock_s;
  logic [CNT_W-1:0]       cnt_dec;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  // Timeout keeps running through WAIT_LOCK/STABLE but must not wrap below zero.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  // NOTE: the synchroniser flops carry no data worth keeping across reset, but they
  // are still cleared so lock_s can never show a stale '1' right after release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else if (run_q) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; a blocking '=' would let later lines see half-updated state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_PLL_RST;
      run_q        <= 1'b0;
      cnt_q        <= RST_LOAD;
      stab_q       <= '0;
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      relock_q     <= '0;
      tmo_q        <= '0;
    end else if (!run_q) begin
      // The release edge itself only arms the sequencer; nothing else moves on it.
      run_q <= 1'b1;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == '0) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= TMO_LOAD;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= S_STABLE;
            stab_q  <= STB_LOAD;
            cnt_q   <= cnt_dec;
          end else if (cnt_q == '0) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= RST_LOAD;
            pll_reset_q <= 1'b1;
            tmo_q       <= (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          end else begin
            cnt_q <= cnt_dec;
          end
        end

        S_STABLE: begin
          if (!lock_s) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= cnt_dec;
          end else if (stab_q == '0) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
          end else if (cnt_q == '0) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= RST_LOAD;
            pll_reset_q <= 1'b1;
            tmo_q       <= (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          end else begin
            stab_q <= stab_q - 1'b1;
            cnt_q  <= cnt_dec;
          end
        end

        S_HOLD: begin
          if (!lock_s) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= TMO_LOAD;
          end else if (cnt_q == '0) begin
            state_q      <= S_RUN;
            sys_resetn_q <= 1'b1;
            locked_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state_q      <= S_WAIT_LOCK;
            cnt_q        <= TMO_LOAD;
            sys_resetn_q <= 1'b0;
            locked_q     <= 1'b0;
            relock_q     <= (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
          end
        end

        default: begin
          state_q      <= S_PLL_RST;
          cnt_q        <= RST_LOAD;
          pll_reset_q  <= 1'b1;
          sys_resetn_q <= 1'b0;
          locked_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_reset     = pll_reset_q;
  assign bus.sys_resetn    = sys_resetn_q;
  assign bus.locked        = locked_q;
  assign bus.relock_count  = relock_q;
  assign bus.timeout_count = tmo_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Event scoreboard for pll_reset_sequencer: expected output transitions (edge, value)
// are queued as stimulus is driven and matched against every observed change.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int RSTC = 3;
  localparam int TMO  = 100;
  localparam int STB  = 8;
  localparam int HLD  = 4;

  logic clk = 1'b0;
  logic resetn;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES        (SYNC),
    .PLL_RST_CYCLES     (RSTC),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .LOCK_STABLE_CYCLES (STB),
    .RESET_HOLD_CYCLES  (HLD),
    .CNT_W              (20)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {K_PLL_RESET, K_SYS_RESETN, K_LOCKED, K_RELOCK, K_TIMEOUT} kind_e;
  typedef struct {
    kind_e kind;
    int    edge_no;
    int    val;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec    = 0;
  int  n_bad    = 0;
  int  edge_n   = 0;
  int  rel_base = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, edge_n - rel_base);
    end
  endtask

  function automatic int rel_edge();
    return edge_n - rel_base;
  endfunction

  task automatic expect_ev(input kind_e k, input int e, input int v);
    ev_t x;
    x.kind    = k;
    x.edge_no = e;
    x.val     = v;
    exp_q.push_back(x);
  endtask

  task automatic score(input kind_e k, input int cur, input int prev);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({k.name(), "_unexpected_change"}, cur, prev);
      return;
    end
    e = exp_q.pop_front();
    check({k.name(), "_kind"}, int'(k), int'(e.kind));
    check({e.kind.name(), "_edge"}, rel_edge(), e.edge_no);
    check({e.kind.name(), "_val"}, cur, e.val);
  endtask

  // Monitor: samples 1 time unit after each rising edge, scores every output change.
  initial begin
    int prev[5];
    int cur[5];
    prev = '{0, 0, 0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      edge_n++;
      cur[0] = int'(bus.pll_reset);
      cur[1] = int'(bus.sys_resetn);
      cur[2] = int'(bus.locked);
      cur[3] = int'(bus.relock_count);
      cur[4] = int'(bus.timeout_count);
      if (resetn) begin
        for (int k = 0; k < 5; k++) begin
          if (cur[k] != prev[k]) score(kind_e'(k), cur[k], prev[k]);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  task automatic to_edge(input int k);
    while (rel_edge() < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn   = 1'b1;
    rel_base = edge_n;
  endtask

  task automatic do_reset(input logic lock);
    resetn       = 1'b0;
    bus.pll_lock = lock;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic drain(input string tag);
    check({tag, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_reset"}, int'(bus.pll_reset), 1);
    check({tag, "_sys_resetn"}, int'(bus.sys_resetn), 0);
    check({tag, "_locked"}, int'(bus.locked), 0);
    check({tag, "_relock_count"}, int'(bus.relock_count), 0);
    check({tag, "_timeout_count"}, int'(bus.timeout_count), 0);
  endtask

  // Relative edge numbering: edge 1 is the first rising edge after resetn release.
  // That edge only arms the sequencer, so PLL_RST ends at RSTC+1 and the FSM's
  // first lock_s sample with lock held from reset is at L0 = RSTC+2.
  localparam int WAIT0 = RSTC + 1;
  localparam int L0    = RSTC + 2;

  initial begin
    int p;
    int drop_at;
    int restore_at;
    int l2;
    int rise;

    resetn       = 1'b1;
    bus.pll_lock = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("por");

    // Power-up with lock already high: release at L0 + STB + HLD = 17.
    release_reset();
    expect_ev(K_PLL_RESET, WAIT0, 0);
    expect_ev(K_SYS_RESETN, L0 + STB + HLD, 1);
    expect_ev(K_LOCKED, L0 + STB + HLD, 1);
    to_edge(20);
    drain("powerup");
    check("powerup_relock_count", int'(bus.relock_count), 0);
    check("powerup_timeout_count", int'(bus.timeout_count), 0);

    // Lock lost in RUN for 5 cycles: drive lands just after edge 20.
    bus.pll_lock = 1'b0;
    expect_ev(K_SYS_RESETN, 20 + SYNC + 1, 0);
    expect_ev(K_LOCKED, 20 + SYNC + 1, 0);
    expect_ev(K_RELOCK, 20 + SYNC + 1, 1);
    to_edge(25);
    bus.pll_lock = 1'b1;
    expect_ev(K_SYS_RESETN, 25 + SYNC + 1 + STB + HLD, 1);
    expect_ev(K_LOCKED, 25 + SYNC + 1 + STB + HLD, 1);
    to_edge(45);
    drain("relock");
    check("relock_count_after_loss", int'(bus.relock_count), 1);

    // Lock drop seen on the second HOLD edge: qualification restarts, no relock count.
    do_reset(1'b1);
    drop_at    = L0 + STB - 2;
    restore_at = drop_at + 3;
    l2         = restore_at + SYNC + 1;
    expect_ev(K_PLL_RESET, WAIT0, 0);
    expect_ev(K_SYS_RESETN, l2 + STB + HLD, 1);
    expect_ev(K_LOCKED, l2 + STB + HLD, 1);
    to_edge(drop_at);
    bus.pll_lock = 1'b0;
    to_edge(restore_at);
    bus.pll_lock = 1'b1;
    to_edge(l2 + STB + HLD + 3);
    drain("hold_drop");
    check("hold_drop_relock_count", int'(bus.relock_count), 0);

    // Lock never comes: PLL reset re-pulses every TMO+RSTC edges.
    do_reset(1'b0);
    expect_ev(K_PLL_RESET, WAIT0, 0);
    for (int n = 1; n <= 3; n++) begin
      rise = WAIT0 + TMO + (n - 1) * (TMO + RSTC);
      expect_ev(K_PLL_RESET, rise, 1);
      expect_ev(K_TIMEOUT, rise, n);
      expect_ev(K_PLL_RESET, rise + RSTC, 0);
    end
    to_edge(WAIT0 + 3 * (TMO + RSTC) + 5);
    drain("no_lock");
    check("no_lock_timeout_count", int'(bus.timeout_count), 3);

    // Chatter high 6 / low 1: HOLD never reached, timeout at WAIT0 + TMO.
    do_reset(1'b1);
    expect_ev(K_PLL_RESET, WAIT0, 0);
    expect_ev(K_PLL_RESET, WAIT0 + TMO, 1);
    expect_ev(K_TIMEOUT, WAIT0 + TMO, 1);
    expect_ev(K_PLL_RESET, WAIT0 + TMO + RSTC, 0);
    for (int k = 1; k <= 110; k++) begin
      to_edge(k);
      bus.pll_lock = ((k % 7) != 6);
    end
    bus.pll_lock = 1'b0;
    to_edge(115);
    drain("chatter");
    check("chatter_timeout_count", int'(bus.timeout_count), 1);

    // 300 forced losses in RUN: relock_count stops at 255.
    do_reset(1'b1);
    expect_ev(K_PLL_RESET, WAIT0, 0);
    expect_ev(K_SYS_RESETN, L0 + STB + HLD, 1);
    expect_ev(K_LOCKED, L0 + STB + HLD, 1);
    p = 20;
    for (int i = 1; i <= 300; i++) begin
      to_edge(p);
      bus.pll_lock = 1'b0;
      expect_ev(K_SYS_RESETN, p + SYNC + 1, 0);
      expect_ev(K_LOCKED, p + SYNC + 1, 0);
      if (i <= 255) expect_ev(K_RELOCK, p + SYNC + 1, i);
      to_edge(p + 2);
      bus.pll_lock = 1'b1;
      expect_ev(K_SYS_RESETN, p + 2 + SYNC + 1 + STB + HLD, 1);
      expect_ev(K_LOCKED, p + 2 + SYNC + 1 + STB + HLD, 1);
      p = p + 20;
    end
    to_edge(p);
    drain("saturate");
    check("saturate_relock_count", int'(bus.relock_count), 255);

    // One more loss, then resetn pulsed while in HOLD (HOLD spans p+13 .. p+16).
    bus.pll_lock = 1'b0;
    expect_ev(K_SYS_RESETN, p + SYNC + 1, 0);
    expect_ev(K_LOCKED, p + SYNC + 1, 0);
    to_edge(p + 2);
    bus.pll_lock = 1'b1;
    to_edge(p + 14);
    drain("sat_hold");
    check("sat_hold_relock_count", int'(bus.relock_count), 255);
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    release_reset();
    expect_ev(K_PLL_RESET, WAIT0, 0);
    to_edge(WAIT0 + 2);
    drain("async_rst_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
